// File: rtl/datapath_seq_pkg.sv
// Shared types and constants for the datapath instruction sequencer.
// Instruction word: opc[15:12] d[11:8] a[7:4] b[3:0].
package datapath_seq_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALTED} state_t;

  localparam logic [3:0] OPC_IN   = 4'b1000;
  localparam logic [3:0] OPC_OUT  = 4'b1001;
  localparam logic [3:0] OPC_JMP  = 4'b1010;
  localparam logic [3:0] OPC_JF   = 4'b1011;
  localparam logic [3:0] OPC_NOP  = 4'b1100;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  localparam logic [7:0] CTRL_WB_ALU = 8'h01;
  localparam logic [7:0] CTRL_WB_IN  = 8'h02;
  localparam logic [7:0] CTRL_OUT_EN = 8'h04;

  // upd_* select which held datapath fields an instruction overwrites
  typedef struct packed {
    logic       wen;
    logic [7:0] ctrl;
    logic       upd_wa;
    logic       upd_raa;
    logic       upd_rab;
    logic       upd_op;
    logic       upd_sel;
    logic [3:0] wa;
    logic [3:0] raa;
    logic [3:0] rab;
    logic [3:0] sel;
    logic [2:0] op;
    logic       jmp;
    logic       jf;
    logic       halt;
    logic [7:0] target;
  } dec_t;

endpackage

// File: rtl/datapath_seq_decode.sv
// Purely combinational instruction decoder: 16-bit instruction word to control struct.
module datapath_seq_decode
  import datapath_seq_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  logic [3:0] opc;
  assign opc = instr[15:12];

  always_comb begin
    dec        = '0;
    dec.wa     = instr[11:8];
    dec.raa    = instr[7:4];
    dec.rab    = instr[3:0];
    dec.sel    = instr[7:4];
    dec.op     = opc[2:0];
    dec.target = instr[7:0];
    if (!opc[3]) begin
      dec.wen     = 1'b1;
      dec.ctrl    = CTRL_WB_ALU;
      dec.upd_wa  = 1'b1;
      dec.upd_raa = 1'b1;
      dec.upd_rab = 1'b1;
      dec.upd_op  = 1'b1;
    end else begin
      case (opc)
        OPC_IN: begin
          dec.wen     = 1'b1;
          dec.ctrl    = CTRL_WB_IN;
          dec.upd_wa  = 1'b1;
          dec.upd_sel = 1'b1;
        end
        OPC_OUT: begin
          dec.ctrl    = CTRL_OUT_EN;
          dec.upd_raa = 1'b1;
        end
        OPC_JMP:  dec.jmp  = 1'b1;
        OPC_JF:   dec.jf   = 1'b1;
        OPC_HALT: dec.halt = 1'b1;
        OPC_NOP:  ;
        default:  ;  // unassigned opcodes behave as NOP
      endcase
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Three-cycle FETCH/DECODE/EXEC sequencer driving the 4-bit register-file/ALU datapath.
// All datapath controls are registered; only imem_addr is combinational from pc.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [7:0]        Ctrl,
  output logic [3:0]        Sel,
  output logic              Wen,
  output logic [3:0]        WA,
  output logic [3:0]        RAA,
  output logic [3:0]        RAB,
  output logic [2:0]        Op,
  input  logic              Flag,
  output logic [15:0]       instr_cnt
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [15:0]         cnt_d;
  logic [7:0]          ctrl_d;
  logic [3:0]          sel_d, wa_d, raa_d, rab_d;
  logic [2:0]          op_d;
  logic                wen_d;
  logic [INSTR_W-1:0]  dec_in;
  dec_t                dec;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // DECODE registers the controls straight from ROM data; EXEC re-decodes the latched word for flow control
  assign dec_in = (state_q == EXEC) ? instr_q : imem_rdata;

  datapath_seq_decode u_decode (
    .instr (dec_in),
    .dec   (dec)
  );

  assign imem_addr = pc_q;
  assign busy      = (state_q == FETCH) || (state_q == DECODE) || (state_q == EXEC);
  assign done      = (state_q == HALTED);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = instr_cnt;
    wen_d   = 1'b0;
    ctrl_d  = 8'h00;
    sel_d   = Sel;
    wa_d    = WA;
    raa_d   = RAA;
    rab_d   = RAB;
    op_d    = Op;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
          cnt_d   = 16'h0000;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        instr_d = imem_rdata;
        state_d = EXEC;
        wen_d   = dec.wen;
        ctrl_d  = dec.ctrl;
        if (dec.upd_wa)  wa_d  = dec.wa;
        if (dec.upd_raa) raa_d = dec.raa;
        if (dec.upd_rab) rab_d = dec.rab;
        if (dec.upd_op)  op_d  = dec.op;
        if (dec.upd_sel) sel_d = dec.sel;
      end
      EXEC: begin
        cnt_d   = sat_inc(instr_cnt);
        state_d = dec.halt ? HALTED : FETCH;
        if (dec.jmp || (dec.jf && Flag)) pc_d = ADDR_W'(dec.target);
        else                             pc_d = pc_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      instr_cnt <= 16'h0000;
      Wen       <= 1'b0;
      Ctrl      <= 8'h00;
      Sel       <= 4'h0;
      WA        <= 4'h0;
      RAA       <= 4'h0;
      RAB       <= 4'h0;
      Op        <= 3'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instr_cnt <= cnt_d;
      Wen       <= wen_d;
      Ctrl      <= ctrl_d;
      Sel       <= sel_d;
      WA        <= wa_d;
      RAA       <= raa_d;
      RAB       <= rab_d;
      Op        <= op_d;
    end
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle instruction sequencer that drives the existing 4-bit register-file/ALU datapath: fetches 16-bit instructions from a synchronous ROM, decodes them, and drives Ctrl/Sel/Wen/WA/RAA/RAB/Op.
- Uses datapath Flag for conditional jumps.
- Sits between the top-level start/done control and the datapath instance; one instruction completes every 3 cycles.

Parameters:
- ADDR_W, 8, program-counter / ROM address width
- INSTR_W, 16, instruction width (fixed format, not for override)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin execution at address 0 (level sampled in IDLE/HALTED)
- busy  out  1  high while executing (FETCH/DECODE/EXEC)
- done  out  1  high in HALTED
- imem_addr  out  ADDR_W  ROM address
- imem_rdata  in  16  ROM data, valid 1 cycle after imem_addr
- Ctrl  out  8  datapath control word
- Sel  out  4  InPort nibble index
- Wen  out  1  register-file write enable
- WA  out  4  write address
- RAA  out  4  read address A
- RAB  out  4  read address B
- Op  out  3  ALU operation
- Flag  in  1  datapath ALU flag (registered in datapath, reflects last ALU op)
- instr_cnt  out  16  retired-instruction counter

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, pc=0, imem_addr=0, Ctrl=0, Sel=0, Wen=0, WA=0, RAA=0, RAB=0, Op=0, busy=0, done=0, instr_cnt=0. Reset wins over every other event, including mid-instruction; no Wen pulse may follow the reset edge.
- Instruction format: opc=[15:12], d=[11:8], a=[7:4], b=[3:0].
  - opc 0xxx: ALU op=opc[2:0]; RAA=a, RAB=b, WA=d, Ctrl=CTRL_WB_ALU, Wen=1.
  - 1000 IN: WA=d, Sel=a, Ctrl=CTRL_WB_IN, Wen=1.
  - 1001 OUT: RAA=a, Ctrl=CTRL_OUT_EN, Wen=0.
  - 1010 JMP: pc={a,b}.
  - 1011 JF: if Flag==1 then pc={a,b}, else pc+1.
  - 1100 NOP.
  - 1111 HALT.
  - Other opcodes (1101, 1110): treated as NOP.
- FSM states and transitions:
  - IDLE: start=1 -> FETCH with pc=0, instr_cnt=0.
  - FETCH: imem_addr=pc -> DECODE.
  - DECODE: latch imem_rdata into instr register -> EXEC.
  - EXEC: datapath outputs driven for exactly this cycle. Wen is high only in EXEC, for exactly 1 cycle, and only for ALU/IN. Next pc is computed here; instr_cnt+1 (including HALT). Next state is FETCH, or HALTED for HALT.
  - HALTED: done=1, outputs idle. start=1 -> FETCH with pc=0, instr_cnt cleared, done falls the next cycle.
- Outputs are registered (Moore) except imem_addr, which is combinational from pc.
- Outside EXEC: Wen=0, Ctrl=0; WA/RAA/RAB/Op/Sel hold their last values.
- JF samples Flag in the EXEC cycle only. The Flag result of an ALU op is visible to a JF issued at earliest in the next instruction.
- pc arithmetic: modulo 2^ADDR_W; pc=255 +1 wraps to 0 with no error.
- instr_cnt: saturates at 16'hFFFF.
- start held high while busy: ignored.

Decomposition:
- Package datapath_seq_pkg:
  - typedef enum state_t {IDLE, FETCH, DECODE, EXEC, HALTED}
  - opcode localparams OPC_IN, OPC_OUT, OPC_JMP, OPC_JF, OPC_NOP, OPC_HALT
  - Ctrl constants CTRL_WB_ALU=8'h01, CTRL_WB_IN=8'h02, CTRL_OUT_EN=8'h04
  - decoded-control struct
- One sub-module, datapath_seq_decode: purely combinational instruction -> control struct. The FSM, pc and counter stay in the top.

Test Plan:
- Reset/idle: rst_n low 3 cycles, start=0 -> all outputs 0, busy=0, done=0 for 10 cycles.
- ALU sequence: ROM[0]=16'h1312 (op1, WA=3, RAA=1, RAB=2), ROM[1]=16'hF000; start pulse -> Wen=1 exactly in cycle 3 after start with WA=3, Op=1, Ctrl=01; done=1 from cycle 7; instr_cnt=2.
- Branching: ROM[0]=16'hB005 (JF ->5) with Flag=0 -> next fetch addr 1. Rerun with Flag=1 -> next fetch addr 5. JMP 16'hA0FF -> fetch addr 255, then wrap to 0.
- IN/OUT: 16'h8470 -> Sel=7, WA=4, Ctrl=02, Wen=1. 16'h9040 -> RAA=4, Ctrl=04, Wen=0.
- Reset mid-operation: assert rst_n=0 during EXEC of an ALU instruction -> Wen=0 on the following cycle, state IDLE, pc=0; a subsequent start reruns from address 0.
- Restart/undefined opcodes: ROM holds 16'hD123 then HALT -> Wen never asserted, instr_cnt=2. start in HALTED -> done drops next cycle, instr_cnt restarts at 0.
